// File: rtl/bw_mac8_pkg.sv
// Shared types and constants for the bw_mac8_stream multiply-accumulate block.
package bw_mac8_pkg;

    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_e;

    localparam int OPND_W    = 8;
    localparam int PROD_W    = 16;
    localparam int COUNT_W   = 16;
    localparam int ACC_W_DEF = 24;

    function automatic logic signed [31:0] sat_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/bw_mac8_stream_mul.sv
// Combinational signed 8x8 Baugh-Wooley multiplier producing a 16-bit product.
module baugh_wooley_mul8
    import bw_mac8_pkg::*;
(
    input  logic signed [OPND_W-1:0] a_i,
    input  logic signed [OPND_W-1:0] b_i,
    output logic signed [PROD_W-1:0] p_o
);

    logic [PROD_W-1:0] sum;
    logic              pp;

    // Sign-row partial products are inverted; the 2^8 and 2^15 correction
    // constants fold the resulting negative offsets back in modulo 2^16.
    always_comb begin
        sum = 16'h8100;
        pp  = 1'b0;
        for (int i = 0; i < OPND_W; i++) begin
            for (int j = 0; j < OPND_W; j++) begin
                pp = a_i[i] & b_i[j];
                if ((i == OPND_W - 1) != (j == OPND_W - 1)) begin
                    pp = ~pp;
                end
                sum = sum + (16'(pp) << (i + j));
            end
        end
    end

    assign p_o = sum;

endmodule

// File: rtl/bw_mac8_stream.sv
// Streaming signed 8x8 MAC: operand register, multiplier, product register,
// then a wide saturating/wrapping accumulator emitting one total per sequence.
module bw_mac8_stream
    import bw_mac8_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [OPND_W-1:0] operand_a,
    input  logic signed [OPND_W-1:0] operand_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  result_acc,
    output logic [COUNT_W-1:0]       result_count,
    output logic                     overflow_flag
);

    localparam logic signed [31:0]      MAX32   = sat_max(ACC_W);
    localparam logic signed [31:0]      MIN32   = sat_min(ACC_W);
    localparam logic signed [ACC_W-1:0] ACC_MAX = MAX32[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] ACC_MIN = MIN32[ACC_W-1:0];

    state_e                    state_q, state_d;
    logic                      accept;

    logic                      vld_p1_q, last_p1_q;
    logic signed [OPND_W-1:0]  a_p1_q, b_p1_q;
    logic signed [PROD_W-1:0]  prod_p1;

    logic                      vld_p2_q, last_p2_q;
    logic signed [PROD_W-1:0]  prod_p2_q;

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0]        cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic signed [ACC_W:0]     sum_ext;

    assign in_ready = (state_q == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;

    // P1 -> P2: combinational product of the registered operands
    baugh_wooley_mul8 u_mul (
        .a_i (a_p1_q),
        .b_i (b_p1_q),
        .p_o (prod_p1)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_ext = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W + 1 - PROD_W){prod_p2_q[PROD_W-1]}}, prod_p2_q};

        // P2 -> accumulator: the extra top bit exposes overflow
        if (vld_p2_q) begin
            if (cnt_q != {COUNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                ovf_d = 1'b1;
                acc_d = SATURATE ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX)
                                 : sum_ext[ACC_W-1:0];
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
            end
        end

        case (state_q)
            ACCUM: begin
                if (accept && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (vld_p2_q && last_p2_q) state_d = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Datapath registers carry no reset; the valids gate their use
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1_q    <= operand_a;
            b_p1_q    <= operand_b;
            last_p1_q <= in_last;
        end
        prod_p2_q <= prod_p1;
        last_p2_q <= last_p1_q;
    end

    assign out_valid     = (state_q == OUTPUT);
    assign result_acc    = acc_q;
    assign result_count  = cnt_q;
    assign overflow_flag = ovf_q;

endmodule

// File: doc/bw_mac8_stream.md
Name: bw_mac8_stream

Overview:
- Streaming signed 8x8 multiply-accumulate stage wrapped around the existing combinational baugh_wooley_mul8 multiplier.
- Accepts a stream of signed operand pairs over a valid/ready handshake and registers them before the multiplier.
- Registers each 16-bit product and sums the products of one sequence, delimited by in_last, into a wide signed accumulator.
- Presents the sequence total on a valid/ready output to the downstream consumer (dot-product / FIR tap sum).

Parameters:
- ACC_W, 24, accumulator and result width in bits (signed); legal 17..32.
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap. overflow_flag is set in both modes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair this cycle
- operand_a  input  8  signed multiplicand
- operand_b  input  8  signed multiplier
- in_last  input  1  pair is the final term of the current sequence
- out_valid  output  1  result_acc/result_count/overflow_flag valid
- out_ready  input  1  downstream accepts the result
- result_acc  output  ACC_W  signed sequence sum
- result_count  output  16  number of terms summed, saturating at 65535
- overflow_flag  output  1  accumulator overflowed at least once in this sequence

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst; the polarity and synchronicity are fixed.
- Reset values: state=ACCUM, all pipeline valids=0, acc=0, count=0, overflow=0, out_valid=0. result_acc, result_count and overflow_flag read 0.
- in_ready = (state==ACCUM) && !rst. It is combinational and does not depend on in_valid.
- Accept: an operand pair is taken when in_valid && in_ready at a rising edge.
- Pipeline, with E0 the accepting edge:
  - E0: operands and last bit captured into stage P1.
  - E1: the baugh_wooley_mul8 product of the P1 operands is captured into stage P2 (16-bit signed).
  - E2: the P2 product is added into acc and count increments.
- Back-to-back: full throughput, one pair per cycle while in ACCUM.
- State ACCUM: accept pairs. An accepted pair with in_last=1 moves the block to DRAIN at that same edge.
- State DRAIN: wait until the last-flagged product is added (edge E2 of that pair), then go to OUTPUT at E2.
  - out_valid is visible in the cycle after E2: latency from last accept to out_valid is 3 edges.
- State OUTPUT: out_valid=1 and outputs are held stable.
  - On out_ready=1 (handshake edge): acc, count and overflow clear to 0, state returns to ACCUM, and in_ready is 1 in the next cycle.
  - out_ready low stalls indefinitely with no data change.
- Arithmetic:
  - The product is sign-extended to ACC_W+1 bits and summed with acc extended to ACC_W+1 bits.
  - Overflow is detected when the top two bits differ.
  - SATURATE=1: clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1). Once saturated, subsequent terms continue from the clamped value.
  - Overflow sets the sticky overflow_flag in both modes.
- Product range is -16256..+16384; (-128)*(-128)=+16384 is legal and exact.
- Count saturates at 65535 and does not wrap.
- Minimum sequence length is 1; a single pair with in_last=1 is a complete sequence. Zero-length sequences do not exist.
- in_valid while in_ready=0 is ignored. The upstream must hold its data, per the standard valid/ready rule.
- rst mid-operation: the in-flight pair, partial acc and pending result are discarded. The block is back in ACCUM with in_ready=1 in the cycle after rst deasserts.

Decomposition:
- Package bw_mac8_pkg:
  - state enum {ACCUM, DRAIN, OUTPUT}
  - PROD_W=16, OPND_W=8, COUNT_W=16
  - default ACC_W and the saturation max/min constant functions
- Sub-module: one instance of baugh_wooley_mul8 between P1 and P2. No other sub-modules.
- Saturation/adder logic stays inline.

Test Plan:
- Single term: (a=-3, b=5, last=1) -> out_valid 3 edges after accept; result_acc=-15, result_count=1, overflow_flag=0.
- Back-to-back 4 terms: (1,2),(-4,3),(127,127),(-128,-128,last), in_valid held high -> one accept per cycle; result_acc=2-12+16129+16384=32503, count=4.
- Output backpressure:
  - out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout.
  - out_ready=1 -> in_ready=1 next cycle, and the next sequence (2,2,last) yields 4, showing acc was cleared.
- Saturation, ACC_W=24, SATURATE=1: 600 terms of (-128)*(-128) -> result_acc=8388607, overflow_flag=1, count=600. Repeat with SATURATE=0 -> result_acc equals the wrapped sum 9830400-16777216=-6946816, overflow_flag=1.
- Reset mid-sequence: after 3 accepted terms, assert rst for one cycle -> out_valid=0 and all outputs 0. A new sequence (7,-7,last) yields -49, count=1.
- Random stress: random in_valid/out_ready gaps, sequence lengths 1..20 and operands -128..127 -> every result matches a reference model sum, with no lost or duplicated terms.
